// File: rtl/door_seq_ctrl.sv
// Landing door sequencer: opens on arrival, runs the dwell timer, closes with reversal.
// Optional obstruction nudge (reopen limit + buzzer) is enabled by defining DOOR_NUDGE_EN.
module door_seq_ctrl #(
  parameter int TRAVEL_TICKS = 50,
  parameter int MAX_REOPEN   = 3
) (
  input  logic       clk,
  input  logic       _rst,
  input  logic       arr,
  input  logic       open_btn,
  input  logic       close_btn,
  input  logic       obstruct,
  input  logic       tmo,
  output logic       tmr_run,
  output logic       tmr_clr_n,
  output logic       door_open_cmd,
  output logic       door_close_cmd,
  output logic       closed,
  output logic [1:0] status,
  output logic       buzzer
);

  localparam int PW = $clog2(TRAVEL_TICKS + 1);
  localparam logic [PW-1:0] POS_ZERO = PW'(0);
  localparam logic [PW-1:0] POS_ONE  = PW'(1);
  localparam logic [PW-1:0] POS_LAST = PW'(TRAVEL_TICKS - 1);
  localparam logic [PW-1:0] POS_FULL = PW'(TRAVEL_TICKS);

  typedef enum logic [1:0] {
    CLOSED    = 2'd0,
    OPENING   = 2'd1,
    OPEN_WAIT = 2'd2,
    CLOSING   = 2'd3
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [PW-1:0] pos_r, pos_nxt_s;
  logic          arr_d_r, tmo_d_r, hold_r;
  logic          arr_rise_s, tmo_fall_s, req_open_s, reverse_s, nudge_s;

  // Parameter sanity is checked at elaboration so a bad build never produces hardware.
  if (TRAVEL_TICKS < 1 || MAX_REOPEN < 0) begin : g_bad_param
    $error("door_seq_ctrl: TRAVEL_TICKS must be >= 1 and MAX_REOPEN >= 0");
  end

  assign arr_rise_s = arr & ~arr_d_r;
  assign tmo_fall_s = tmo_d_r & ~tmo;
  assign req_open_s = open_btn | obstruct;
  // Once the reopen budget is spent, only an explicit open request may reverse.
  assign reverse_s  = open_btn | (obstruct & ~nudge_s);

`ifdef DOOR_NUDGE_EN
  localparam int RW = $clog2(MAX_REOPEN + 2);
  localparam logic [RW-1:0] REOPEN_MAX = RW'(MAX_REOPEN);

  logic [RW-1:0] reopen_r, reopen_nxt_s;

  assign nudge_s = (reopen_r >= REOPEN_MAX);

  // Reopen counter: cleared whenever the door ends up shut, saturating count of reversals.
  always_comb begin
    reopen_nxt_s = reopen_r;
    if (state_nxt_s == CLOSED) begin
      reopen_nxt_s = {RW{1'b0}};
    end else if ((state_r == CLOSING) && (state_nxt_s == OPENING) && (reopen_r < REOPEN_MAX)) begin
      reopen_nxt_s = reopen_r + RW'(1);
    end else begin
      reopen_nxt_s = reopen_r;
    end
  end
`else
  assign nudge_s = 1'b0;
`endif

  // Next-state and door position; position is clamped so it stays within 0..TRAVEL_TICKS.
  always_comb begin
    state_nxt_s = state_r;
    pos_nxt_s   = pos_r;
    case (state_r)
      CLOSED: begin
        pos_nxt_s = POS_ZERO;
        if (arr_rise_s | (arr & open_btn)) begin
          state_nxt_s = OPENING;
        end else begin
          state_nxt_s = CLOSED;
        end
      end
      OPENING: begin
        // ">=" also covers a reversal taken at full open, which must not overshoot.
        if (pos_r >= POS_LAST) begin
          state_nxt_s = OPEN_WAIT;
          pos_nxt_s   = POS_FULL;
        end else begin
          pos_nxt_s = pos_r + POS_ONE;
        end
      end
      OPEN_WAIT: begin
        if (req_open_s) begin
          state_nxt_s = OPEN_WAIT;
        end else if (close_btn | tmo_fall_s) begin
          state_nxt_s = CLOSING;
        end else begin
          state_nxt_s = OPEN_WAIT;
        end
      end
      CLOSING: begin
        if (reverse_s) begin
          state_nxt_s = OPENING;
        end else if (pos_r <= POS_ONE) begin
          state_nxt_s = CLOSED;
          pos_nxt_s   = POS_ZERO;
        end else begin
          pos_nxt_s = pos_r - POS_ONE;
        end
      end
      default: begin
        state_nxt_s = CLOSED;
        pos_nxt_s   = POS_ZERO;
      end
    endcase
  end

  // State, edge-detect history and outputs; outputs are the decode of the next state so
  // they always equal the decode of the state register.
  always_ff @(posedge clk) begin
    if (!_rst) begin
      state_r        <= CLOSED;
      pos_r          <= POS_ZERO;
      arr_d_r        <= 1'b0;
      tmo_d_r        <= 1'b0;
      hold_r         <= 1'b0;
      tmr_run        <= 1'b0;
      tmr_clr_n      <= 1'b0;
      door_open_cmd  <= 1'b0;
      door_close_cmd <= 1'b0;
      closed         <= 1'b1;
      status         <= 2'd0;
      buzzer         <= 1'b0;
`ifdef DOOR_NUDGE_EN
      reopen_r       <= {RW{1'b0}};
`endif
    end else begin
      state_r        <= state_nxt_s;
      pos_r          <= pos_nxt_s;
      arr_d_r        <= arr;
      tmo_d_r        <= tmo;
      hold_r         <= req_open_s;
      tmr_run        <= (state_nxt_s == OPEN_WAIT) & ~req_open_s;
      tmr_clr_n      <= (state_nxt_s == OPEN_WAIT) & ~req_open_s;
      door_open_cmd  <= (state_nxt_s == OPENING);
      door_close_cmd <= (state_nxt_s == CLOSING);
      closed         <= (state_nxt_s == CLOSED);
      status         <= state_nxt_s;
`ifdef DOOR_NUDGE_EN
      reopen_r       <= reopen_nxt_s;
      buzzer         <= (state_nxt_s == CLOSING) & (reopen_nxt_s >= REOPEN_MAX);
`else
      buzzer         <= 1'b0;
`endif
    end
  end

  // hold_r mirrors the timer-hold condition seen by the dwell timer outputs.
  logic hold_unused_s;
  assign hold_unused_s = hold_r;

endmodule

// File: tb/tb_door_seq_ctrl.sv
// Directed bench for door_seq_ctrl with TRAVEL_TICKS=4, MAX_REOPEN=2.
// Build with or without DOOR_NUDGE_EN; expectations follow the macro.
module tb_door_seq_ctrl;

  logic       clk = 1'b0;
  logic       _rst, arr, open_btn, close_btn, obstruct, tmo;
  logic       tmr_run, tmr_clr_n, door_open_cmd, door_close_cmd, closed, buzzer;
  logic [1:0] status;

  int n_chk  = 0;
  int n_fail = 0;

  door_seq_ctrl #(.TRAVEL_TICKS(4), .MAX_REOPEN(2)) dut (
    .clk(clk), ._rst(_rst), .arr(arr), .open_btn(open_btn), .close_btn(close_btn),
    .obstruct(obstruct), .tmo(tmo), .tmr_run(tmr_run), .tmr_clr_n(tmr_clr_n),
    .door_open_cmd(door_open_cmd), .door_close_cmd(door_close_cmd), .closed(closed),
    .status(status), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_st(input string tag, input int st);
    chk({tag, "_status"}, 32'(status), 32'(st));
    chk({tag, "_open"},   32'(door_open_cmd),  32'(st == 1));
    chk({tag, "_close"},  32'(door_close_cmd), 32'(st == 3));
    chk({tag, "_closed"}, 32'(closed),         32'(st == 0));
  endtask

  task automatic chk_tmr(input string tag, input logic run, input logic clrn);
    chk({tag, "_run"},  32'(tmr_run),   32'(run));
    chk({tag, "_clrn"}, 32'(tmr_clr_n), 32'(clrn));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    _rst = 1'b0; arr = 1'b0; open_btn = 1'b0; close_btn = 1'b0; obstruct = 1'b0; tmo = 1'b0;
    step(); step();
    chk_st("rst", 0);
    chk_tmr("rst", 1'b0, 1'b0);
    chk("rst_buzz", 32'(buzzer), 32'd0);
    _rst = 1'b1;
    step();
    chk_st("idle", 0);

    // Arrival: four OPENING cycles then OPEN_WAIT with the timer running.
    arr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_st($sformatf("open%0d", i), 1);
    end
    step();
    chk_st("ow", 2);
    chk_tmr("ow", 1'b1, 1'b1);

    // Dwell end on tmo falling edge, then four CLOSING cycles.
    tmo = 1'b1; step(); chk_st("tmo_hi", 2);
    tmo = 1'b0; step(); chk_st("tmo_fall", 3);
    chk_tmr("closing", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_st($sformatf("close%0d", i), 3);
    end
    step();
    chk_st("shut", 0);
    chk_tmr("shut", 1'b0, 1'b0);

    // CLOSED: arr level without edge and close_btn do nothing; arr & open_btn reopens.
    close_btn = 1'b1; step(); chk_st("cl_ign", 0);
    close_btn = 1'b0; open_btn = 1'b1; step(); chk_st("arr_open", 1);
    open_btn = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk_st("reopen_last", 1);
    step(); chk_st("ow2", 2);

    // Hold: open_btn held while tmo toggles; timer cleared, falling edges discarded.
    open_btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tmo = (i % 2 == 0) ? 1'b1 : 1'b0;
      step();
      chk($sformatf("hold%0d_st", i), 32'(status), 32'd2);
      chk($sformatf("hold%0d_clrn", i), 32'(tmr_clr_n), 32'd0);
    end
    open_btn = 1'b0; tmo = 1'b0;
    step(); chk_st("rel", 2); chk_tmr("rel", 1'b1, 1'b1);
    tmo = 1'b1; step(); chk_st("rel_hi", 2);
    tmo = 1'b0; step(); chk_st("rel_fall", 3);

    // Obstruction at pos=2 reverses for two OPENING cycles.
    step(); step(); chk_st("pos2", 3);
    obstruct = 1'b1; step(); chk_st("rev0", 1);
    obstruct = 1'b0; step(); chk_st("rev1", 1);
    step(); chk_st("rev_ow", 2);

    // Priority: open_btn beats close_btn; close_btn alone closes next cycle.
    open_btn = 1'b1; close_btn = 1'b1; step(); chk_st("prio", 2);
    open_btn = 1'b0; step(); chk_st("cbtn", 3);
    close_btn = 1'b0; step(); chk_st("cbtn2", 3);

    // Mid-CLOSING reset returns every output to its reset value.
    _rst = 1'b0; step();
    chk_st("mid_rst", 0);
    chk_tmr("mid_rst", 1'b0, 1'b0);
    chk("mid_rst_buzz", 32'(buzzer), 32'd0);
    _rst = 1'b1;

    // arr_d restarted at 0, so the held arr is seen as a new arrival.
    step(); chk_st("arr_again", 1);
    for (int i = 0; i < 3; i++) step();
    step(); chk_st("ow3", 2);

    // Two reversals at full open; each OPENING lasts one cycle with no overshoot.
    for (int r = 0; r < 2; r++) begin
      close_btn = 1'b1; step(); close_btn = 1'b0;
      chk_st($sformatf("n%0d_cl", r), 3);
      chk($sformatf("n%0d_buzz", r), 32'(buzzer), 32'd0);
      obstruct = 1'b1; step(); obstruct = 1'b0;
      chk_st($sformatf("n%0d_rev", r), 1);
      step(); chk_st($sformatf("n%0d_ow", r), 2);
    end

    close_btn = 1'b1; step(); close_btn = 1'b0;
    chk_st("n2_cl", 3);
`ifdef DOOR_NUDGE_EN
    chk("n2_buzz", 32'(buzzer), 32'd1);
    obstruct = 1'b1; step(); obstruct = 1'b0;
    chk_st("nudge0", 3); chk("nudge0_buzz", 32'(buzzer), 32'd1);
    step(); chk_st("nudge1", 3); chk("nudge1_buzz", 32'(buzzer), 32'd1);
    step(); chk_st("nudge2", 3);
    step(); chk_st("nudge_shut", 0); chk("nudge_shut_buzz", 32'(buzzer), 32'd0);
`else
    chk("n2_buzz", 32'(buzzer), 32'd0);
    obstruct = 1'b1; step(); obstruct = 1'b0;
    chk_st("n2_rev", 1); chk("n2_rev_buzz", 32'(buzzer), 32'd0);
    step(); chk_st("n2_ow", 2);
    close_btn = 1'b1; step(); close_btn = 1'b0;
    chk_st("n2_cl2", 3);
    for (int i = 0; i < 3; i++) step();
    step(); chk_st("n2_shut", 0);
`endif

    // After a full close the reopen count is back to zero: obstruct reverses again.
    open_btn = 1'b1; step(); open_btn = 1'b0;
    chk_st("fin_open", 1);
    for (int i = 0; i < 3; i++) step();
    step(); chk_st("fin_ow", 2);
    close_btn = 1'b1; step(); close_btn = 1'b0;
    chk_st("fin_cl", 3); chk("fin_buzz", 32'(buzzer), 32'd0);
    obstruct = 1'b1; step(); obstruct = 1'b0;
    chk_st("fin_rev", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
